// File: rtl/core_branch_resolve_pkg.sv
// Shared branch-pipeline types: target-type encodings, resolver FSM states and
// the per-lane correction record flags.
package core_branch_resolve_pkg;

  localparam logic [1:0] TT_NONE   = 2'd0;
  localparam logic [1:0] TT_CALL   = 2'd1;
  localparam logic [1:0] TT_RETURN = 2'd2;
  localparam logic [1:0] TT_IMM    = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } br_state_e;

  typedef struct packed {
    logic miss;
    logic taken;
    logic cond;
    logic need_update;
  } br_upd_flags_t;

  // Conditional branch: some, but not every, compare outcome takes it.
  function automatic logic cmp_is_cond(input logic [2:0] en);
    return (|en) & ~(&en);
  endfunction

endpackage

// File: rtl/core_branch_resolve_if.sv
// Execute-stage branch bus: per-lane resolve inputs, BPU correction records
// and the frontend redirect handshake.
interface core_branch_resolve_if #(
  parameter int LANES     = 2,
  parameter int ADDR_W    = 32,
  parameter int RAS_PTR_W = 3,
  parameter int META_W    = 16,
  parameter int CNT_W     = 32
);
  logic [LANES-1:0]                valid_i;
  logic [LANES-1:0][1:0]           target_type_i;
  logic [LANES-1:0][3:0]           cmp_type_i;
  logic [LANES-1:0][ADDR_W-1:0]    pc_i;
  logic [LANES-1:0][ADDR_W-1:0]    target_i;
  logic [LANES-1:0][31:0]          r0_i;
  logic [LANES-1:0][31:0]          r1_i;
  logic [LANES-1:0]                pred_taken_i;
  logic [LANES-1:0]                pred_dir_type_i;
  logic [LANES-1:0][ADDR_W-1:0]    pred_pc_i;
  logic [LANES-1:0][1:0]           pred_target_type_i;
  logic [LANES-1:0][RAS_PTR_W-1:0] pred_ras_ptr_i;
  logic [LANES-1:0][META_W-1:0]    pred_meta_i;

  logic [LANES-1:0]                upd_valid_o;
  logic [LANES-1:0]                upd_miss_o;
  logic [LANES-1:0]                upd_taken_o;
  logic [LANES-1:0]                upd_cond_o;
  logic [LANES-1:0]                upd_need_update_o;
  logic [LANES-1:0][ADDR_W-1:0]    upd_pc_o;
  logic [LANES-1:0][1:0]           upd_target_type_o;
  logic [LANES-1:0][RAS_PTR_W-1:0] upd_ras_ptr_o;
  logic [LANES-1:0][META_W-1:0]    upd_meta_o;

  logic                            redirect_valid_o;
  logic [ADDR_W-1:0]               redirect_pc_o;
  logic                            redirect_ready_i;
  logic                            busy_o;
  logic [CNT_W-1:0]                br_cnt_o;
  logic [CNT_W-1:0]                miss_cnt_o;

  modport master (
    output valid_i, target_type_i, cmp_type_i, pc_i, target_i, r0_i, r1_i,
           pred_taken_i, pred_dir_type_i, pred_pc_i, pred_target_type_i,
           pred_ras_ptr_i, pred_meta_i, redirect_ready_i,
    input  upd_valid_o, upd_miss_o, upd_taken_o, upd_cond_o, upd_need_update_o,
           upd_pc_o, upd_target_type_o, upd_ras_ptr_o, upd_meta_o,
           redirect_valid_o, redirect_pc_o, busy_o, br_cnt_o, miss_cnt_o
  );

  modport slave (
    input  valid_i, target_type_i, cmp_type_i, pc_i, target_i, r0_i, r1_i,
           pred_taken_i, pred_dir_type_i, pred_pc_i, pred_target_type_i,
           pred_ras_ptr_i, pred_meta_i, redirect_ready_i,
    output upd_valid_o, upd_miss_o, upd_taken_o, upd_cond_o, upd_need_update_o,
           upd_pc_o, upd_target_type_o, upd_ras_ptr_o, upd_meta_o,
           redirect_valid_o, redirect_pc_o, busy_o, br_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/core_branch_eval.sv
// Combinational single-lane branch evaluator: direction, mispredict, resolved
// next PC and corrected RAS pointer.
module core_branch_eval
  import core_branch_resolve_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int RAS_PTR_W = 3
) (
  input  logic                 valid_i,
  input  logic [1:0]           target_type_i,
  input  logic [3:0]           cmp_type_i,
  input  logic [ADDR_W-1:0]    pc_i,
  input  logic [ADDR_W-1:0]    target_i,
  input  logic [31:0]          r0_i,
  input  logic [31:0]          r1_i,
  input  logic                 pred_taken_i,
  input  logic [ADDR_W-1:0]    pred_pc_i,
  input  logic [1:0]           pred_target_type_i,
  input  logic [RAS_PTR_W-1:0] pred_ras_ptr_i,
  output br_upd_flags_t        flags_o,
  output logic [ADDR_W-1:0]    resolved_o,
  output logic [RAS_PTR_W-1:0] ras_ptr_o
);
  logic [32:0] a0, a1;
  logic        taken;

  // Biasing the sign bit turns a signed compare into an unsigned one.
  assign a0 = {~r0_i[31] & cmp_type_i[0], r0_i};
  assign a1 = {~r1_i[31] & cmp_type_i[0], r1_i};

  assign taken      = |({a1 < a0, a1 == a0, a1 > a0} & cmp_type_i[3:1]);
  assign resolved_o = taken ? target_i : pc_i + ADDR_W'(4);

  always_comb begin
    flags_o.taken       = taken;
    flags_o.cond        = cmp_is_cond(cmp_type_i[3:1]);
    flags_o.miss        = valid_i & (taken | pred_taken_i)
                        & ((pred_taken_i != taken) | (pred_pc_i != resolved_o));
    flags_o.need_update = (target_type_i != TT_NONE)
                        | (target_type_i != pred_target_type_i);
    case (target_type_i)
      TT_CALL:   ras_ptr_o = pred_ras_ptr_i + RAS_PTR_W'(1);
      TT_RETURN: ras_ptr_o = pred_ras_ptr_i - RAS_PTR_W'(1);
      default:   ras_ptr_o = pred_ras_ptr_i;
    endcase
  end
endmodule

// File: rtl/core_branch_resolve.sv
// Multi-lane branch resolver: oldest-mispredict arbitration, held frontend
// redirect, registered BPU correction records and saturating statistics.
module core_branch_resolve
  import core_branch_resolve_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int ADDR_W    = 32,
  parameter int RAS_PTR_W = 3,
  parameter int META_W    = 16,
  parameter int CNT_W     = 32
) (
  input logic                clk,
  input logic                rst,
  core_branch_resolve_if.slave bus
);
  br_upd_flags_t [LANES-1:0]                flags;
  logic          [LANES-1:0][ADDR_W-1:0]    resolved;
  logic          [LANES-1:0][RAS_PTR_W-1:0] ras_ptr;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    core_branch_eval #(.ADDR_W(ADDR_W), .RAS_PTR_W(RAS_PTR_W)) u_eval (
      .valid_i            (bus.valid_i[g]),
      .target_type_i      (bus.target_type_i[g]),
      .cmp_type_i         (bus.cmp_type_i[g]),
      .pc_i               (bus.pc_i[g]),
      .target_i           (bus.target_i[g]),
      .r0_i               (bus.r0_i[g]),
      .r1_i               (bus.r1_i[g]),
      .pred_taken_i       (bus.pred_taken_i[g]),
      .pred_pc_i          (bus.pred_pc_i[g]),
      .pred_target_type_i (bus.pred_target_type_i[g]),
      .pred_ras_ptr_i     (bus.pred_ras_ptr_i[g]),
      .flags_o            (flags[g]),
      .resolved_o         (resolved[g]),
      .ras_ptr_o          (ras_ptr[g])
    );
  end

  br_state_e         state_q, state_d;
  logic              accept_en, redirect_valid, busy;
  logic [LANES-1:0]  keep, lane_acc;
  logic              win_any;
  logic [ADDR_W-1:0] win_pc;
  logic [CNT_W:0]    n_acc, br_sum, miss_sum;

  // Lanes younger than the oldest mispredict are on the wrong path.
  always_comb begin
    keep    = '0;
    win_any = 1'b0;
    win_pc  = '0;
    for (int i = 0; i < LANES; i++) begin
      keep[i] = ~win_any;
      if (!win_any && flags[i].miss) begin
        win_any = 1'b1;
        win_pc  = resolved[i];
      end
    end
  end

  assign lane_acc = bus.valid_i & keep & {LANES{accept_en}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (win_any)              state_d = ST_PEND;
      ST_PEND: if (bus.redirect_ready_i) state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept_en      = (state_q == ST_IDLE);
    redirect_valid = (state_q == ST_PEND);
    busy           = (state_q == ST_PEND);
  end

  logic [LANES-1:0]                upd_valid_q, upd_miss_q, upd_taken_q;
  logic [LANES-1:0]                upd_cond_q, upd_need_q;
  logic [LANES-1:0][ADDR_W-1:0]    upd_pc_q;
  logic [LANES-1:0][1:0]           upd_tt_q;
  logic [LANES-1:0][RAS_PTR_W-1:0] upd_ras_q;
  logic [LANES-1:0][META_W-1:0]    upd_meta_q;
  logic [ADDR_W-1:0]               redirect_pc_q;
  logic [CNT_W-1:0]                br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    n_acc = '0;
    for (int i = 0; i < LANES; i++) n_acc = n_acc + (CNT_W+1)'(lane_acc[i]);
    br_sum     = {1'b0, br_cnt_q} + n_acc;
    miss_sum   = {1'b0, miss_cnt_q} + (CNT_W+1)'(accept_en & win_any);
    br_cnt_d   = br_sum[CNT_W]   ? '1 : br_sum[CNT_W-1:0];
    miss_cnt_d = miss_sum[CNT_W] ? '1 : miss_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_valid_q   <= '0;
      upd_miss_q    <= '0;
      upd_taken_q   <= '0;
      upd_cond_q    <= '0;
      upd_need_q    <= '0;
      upd_pc_q      <= '0;
      upd_tt_q      <= '0;
      upd_ras_q     <= '0;
      upd_meta_q    <= '0;
      redirect_pc_q <= '0;
      br_cnt_q      <= '0;
      miss_cnt_q    <= '0;
    end else begin
      upd_valid_q <= lane_acc;
      for (int i = 0; i < LANES; i++) begin
        upd_miss_q[i]  <= flags[i].miss & keep[i];
        upd_taken_q[i] <= flags[i].taken;
        upd_cond_q[i]  <= flags[i].cond;
        upd_need_q[i]  <= flags[i].need_update;
      end
      upd_pc_q   <= bus.pc_i;
      upd_tt_q   <= bus.target_type_i;
      upd_ras_q  <= ras_ptr;
      upd_meta_q <= bus.pred_meta_i;
      if (accept_en && win_any) redirect_pc_q <= win_pc;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.upd_valid_o       = upd_valid_q;
  assign bus.upd_miss_o        = upd_miss_q;
  assign bus.upd_taken_o       = upd_taken_q;
  assign bus.upd_cond_o        = upd_cond_q;
  assign bus.upd_need_update_o = upd_need_q;
  assign bus.upd_pc_o          = upd_pc_q;
  assign bus.upd_target_type_o = upd_tt_q;
  assign bus.upd_ras_ptr_o     = upd_ras_q;
  assign bus.upd_meta_o        = upd_meta_q;
  assign bus.redirect_valid_o  = redirect_valid;
  assign bus.redirect_pc_o     = redirect_pc_q;
  assign bus.busy_o            = busy;
  assign bus.br_cnt_o          = br_cnt_q;
  assign bus.miss_cnt_o        = miss_cnt_q;
endmodule

// File: tb/tb_core_branch_resolve.sv
// Directed bench for core_branch_resolve: arbitration, redirect hold,
// RAS wrap, counter saturation (CNT_W=4) and asynchronous reset.
module tb_core_branch_resolve;
  import core_branch_resolve_pkg::*;

  localparam int LANES = 2, ADDR_W = 32, RAS_PTR_W = 3, META_W = 16, CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  core_branch_resolve_if #(.LANES(LANES), .ADDR_W(ADDR_W), .RAS_PTR_W(RAS_PTR_W),
                           .META_W(META_W), .CNT_W(CNT_W)) bus ();

  core_branch_resolve #(.LANES(LANES), .ADDR_W(ADDR_W), .RAS_PTR_W(RAS_PTR_W),
                        .META_W(META_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic v, input logic [3:0] cmp,
                          input logic [31:0] r0, input logic [31:0] r1,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic [1:0] tt, input logic pt,
                          input logic [31:0] ppc, input logic [1:0] ptt,
                          input logic [2:0] pras, input logic [15:0] meta);
    bus.valid_i[l]            = v;
    bus.cmp_type_i[l]         = cmp;
    bus.r0_i[l]               = r0;
    bus.r1_i[l]               = r1;
    bus.pc_i[l]               = pc;
    bus.target_i[l]           = tgt;
    bus.target_type_i[l]      = tt;
    bus.pred_taken_i[l]       = pt;
    bus.pred_dir_type_i[l]    = 1'b1;
    bus.pred_pc_i[l]          = ppc;
    bus.pred_target_type_i[l] = ptt;
    bus.pred_ras_ptr_i[l]     = pras;
    bus.pred_meta_i[l]        = meta;
  endtask

  task automatic clr_lane(input int l);
    set_lane(l, 1'b0, 4'b0000, 0, 0, 0, 0, TT_NONE, 1'b0, 0, TT_NONE, 3'd0, 16'h0);
  endtask

  // Signed r1(-1) < r0(1), predicted taken to 0x100: correct.
  task automatic lane_ok(input int l);
    set_lane(l, 1'b1, 4'b1001, 32'd1, 32'hFFFF_FFFF, 32'h80, 32'h100, TT_IMM,
             1'b1, 32'h100, TT_IMM, 3'd0, 16'hBEEF);
  endtask

  // beq r0==r1 taken, predicted not-taken: mispredict to tgt.
  task automatic lane_miss(input int l, input logic [31:0] pc, input logic [31:0] tgt);
    set_lane(l, 1'b1, 4'b0100, 32'd5, 32'd5, pc, tgt, TT_IMM,
             1'b0, pc + 32'd4, TT_IMM, 3'd0, 16'h0);
  endtask

  initial begin
    bus.redirect_ready_i = 1'b0;
    clr_lane(0);
    clr_lane(1);
    #2;
    chk("rst_rv",   64'(bus.redirect_valid_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o),           64'd0);
    chk("rst_uv",   64'(bus.upd_valid_o),      64'd0);
    chk("rst_rpc",  64'(bus.redirect_pc_o),    64'd0);
    chk("rst_br",   64'(bus.br_cnt_o),         64'd0);
    cycle();
    rst = 1'b0;

    // lane0 correct signed-lt branch
    lane_ok(0);
    cycle();
    chk("t1_uv",   64'(bus.upd_valid_o),       64'b01);
    chk("t1_miss", 64'(bus.upd_miss_o),        64'b00);
    chk("t1_tkn",  64'(bus.upd_taken_o[0]),    64'd1);
    chk("t1_cond", 64'(bus.upd_cond_o[0]),     64'd1);
    chk("t1_need", 64'(bus.upd_need_update_o[0]), 64'd1);
    chk("t1_meta", 64'(bus.upd_meta_o[0]),     64'hBEEF);
    chk("t1_pc",   64'(bus.upd_pc_o[0]),       64'h80);
    chk("t1_rv",   64'(bus.redirect_valid_o),  64'd0);
    chk("t1_br",   64'(bus.br_cnt_o),          64'd1);

    // lane1 beq mispredict, redirect held for 3 cycles
    lane_miss(1, 32'h200, 32'h300);
    cycle();
    chk("t2_uv",   64'(bus.upd_valid_o),      64'b11);
    chk("t2_miss", 64'(bus.upd_miss_o),       64'b10);
    chk("t2_pc1",  64'(bus.upd_pc_o[1]),      64'h200);
    chk("t2_rv",   64'(bus.redirect_valid_o), 64'd1);
    chk("t2_busy", 64'(bus.busy_o),           64'd1);
    chk("t2_rpc",  64'(bus.redirect_pc_o),    64'h300);
    chk("t2_br",   64'(bus.br_cnt_o),         64'd3);
    chk("t2_mc",   64'(bus.miss_cnt_o),       64'd1);
    lane_miss(0, 32'h1000, 32'h2000);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("hold_rv",  64'(bus.redirect_valid_o), 64'd1);
      chk("hold_rpc", 64'(bus.redirect_pc_o),    64'h300);
      chk("hold_uv",  64'(bus.upd_valid_o),      64'd0);
      chk("hold_br",  64'(bus.br_cnt_o),         64'd3);
      chk("hold_mc",  64'(bus.miss_cnt_o),       64'd1);
    end
    bus.redirect_ready_i = 1'b1;
    cycle();
    bus.redirect_ready_i = 1'b0;
    chk("hs_rv", 64'(bus.redirect_valid_o), 64'd0);
    chk("hs_uv", 64'(bus.upd_valid_o),      64'd0);
    chk("hs_br", 64'(bus.br_cnt_o),         64'd3);
    chk("hs_mc", 64'(bus.miss_cnt_o),       64'd1);

    // both lanes mispredict: oldest wins
    lane_miss(0, 32'h400, 32'h500);
    lane_miss(1, 32'h600, 32'h700);
    cycle();
    chk("t3_uv",   64'(bus.upd_valid_o),   64'b01);
    chk("t3_miss", 64'(bus.upd_miss_o),    64'b01);
    chk("t3_rpc",  64'(bus.redirect_pc_o), 64'h500);
    chk("t3_mc",   64'(bus.miss_cnt_o),    64'd2);
    chk("t3_br",   64'(bus.br_cnt_o),      64'd4);
    bus.redirect_ready_i = 1'b1;
    cycle();
    chk("t3_hs_rv", 64'(bus.redirect_valid_o), 64'd0);
    chk("t3_hs_mc", 64'(bus.miss_cnt_o),       64'd2);

    // ready held high in IDLE does nothing
    lane_ok(0);
    clr_lane(1);
    cycle();
    chk("rdy_rv", 64'(bus.redirect_valid_o), 64'd0);
    chk("rdy_uv", 64'(bus.upd_valid_o),      64'b01);
    chk("rdy_br", 64'(bus.br_cnt_o),         64'd5);
    bus.redirect_ready_i = 1'b0;

    // RAS pointer wraps: call 7 -> 0, return 0 -> 7
    set_lane(0, 1'b1, 4'b1110, 32'd3, 32'd9, 32'h800, 32'h900, TT_CALL,
             1'b1, 32'h900, TT_CALL, 3'd7, 16'h0);
    set_lane(1, 1'b1, 4'b1110, 32'd3, 32'd9, 32'h904, 32'hA00, TT_RETURN,
             1'b1, 32'hA00, TT_RETURN, 3'd0, 16'h0);
    cycle();
    chk("ras",     64'(bus.upd_ras_ptr_o), 64'h38);
    chk("ras_uv",  64'(bus.upd_valid_o),   64'b11);
    chk("ras_tkn", 64'(bus.upd_taken_o),   64'b11);
    chk("ras_cnd", 64'(bus.upd_cond_o),    64'b00);
    chk("ras_rv",  64'(bus.redirect_valid_o), 64'd0);
    chk("ras_br",  64'(bus.br_cnt_o),      64'd7);

    // unsigned compare: 0xFFFFFFFF is not < 1; need_update cases
    set_lane(0, 1'b1, 4'b1000, 32'd1, 32'hFFFF_FFFF, 32'hB00, 32'hC00, TT_NONE,
             1'b0, 32'hB04, TT_NONE, 3'd2, 16'h0);
    set_lane(1, 1'b1, 4'b0000, 32'd0, 32'd0, 32'hB04, 32'hD00, TT_NONE,
             1'b0, 32'hB08, TT_IMM, 3'd2, 16'h0);
    cycle();
    chk("u_tkn",  64'(bus.upd_taken_o),       64'b00);
    chk("u_miss", 64'(bus.upd_miss_o),        64'b00);
    chk("u_need", 64'(bus.upd_need_update_o), 64'b10);
    chk("u_cond", 64'(bus.upd_cond_o),        64'b01);
    chk("u_br",   64'(bus.br_cnt_o),          64'd9);

    // br_cnt saturates at 15 with CNT_W=4
    for (int k = 0; k < 4; k++) cycle();
    chk("sat_br", 64'(bus.br_cnt_o),         64'd15);
    chk("sat_rv", 64'(bus.redirect_valid_o), 64'd0);

    // asynchronous reset mid-PEND
    lane_miss(0, 32'h400, 32'h500);
    clr_lane(1);
    cycle();
    chk("pre_rv", 64'(bus.redirect_valid_o), 64'd1);
    chk("pre_mc", 64'(bus.miss_cnt_o),       64'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rv",  64'(bus.redirect_valid_o), 64'd0);
    chk("arst_bsy", 64'(bus.busy_o),           64'd0);
    chk("arst_rpc", 64'(bus.redirect_pc_o),    64'd0);
    chk("arst_br",  64'(bus.br_cnt_o),         64'd0);
    chk("arst_mc",  64'(bus.miss_cnt_o),       64'd0);
    chk("arst_uv",  64'(bus.upd_valid_o),      64'd0);
    clr_lane(0);
    cycle();
    rst = 1'b0;
    cycle();
    chk("post_rv", 64'(bus.redirect_valid_o), 64'd0);
    chk("post_br", 64'(bus.br_cnt_o),         64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
